pixel_write_buffer: RTL and testbench

- Downstream stage for the coordinate-transform units (rotate / zoom / grayscale); takes the place of the plain RAM write stage.
- Accepts 64-bit pixel words {x[49:41], y[40:32], rgb[23:0]} on a valid/ready handshake and bounds-checks coordinates.
- Buffers in-range pixels in a small FIFO and drives one RAM write port, with back-pressure from the RAM.
- Counts dropped pixels and flags end of frame.

---
 rtl/img_pkg.sv | 32 +++
 rtl/pwb_fifo.sv | 56 +++++
 rtl/pixel_write_buffer.sv | 153 +++++++++++++++
 tb/tb_pixel_write_buffer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared image geometry, pixel-word field positions and write-entry type
// for the transform pipeline's output stage.
package img_pkg;

  localparam int IMG_W        = 320;
  localparam int IMG_H        = 320;
  localparam int FRAME_PIXELS = 102400;
  localparam int TMP_OFFSET   = 131072;

  localparam int X_MSB = 49;
  localparam int X_LSB = 41;
  localparam int Y_MSB = 40;
  localparam int Y_LSB = 32;

  typedef logic [8:0]  coord_t;
  typedef logic [63:0] pix_word_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [23:0] rgb;
  } wr_entry_t;

  function automatic logic [31:0] pix_addr(
    input coord_t      x,
    input coord_t      y,
    input int unsigned w,
    input int unsigned off
  );
    return 32'(x) + 32'(y) * 32'(w) + 32'(off);
  endfunction

endpackage

// File: rtl/pwb_fifo.sv
// Small synchronous FIFO of RAM write entries; pointers wrap naturally,
// count carries one extra bit to tell full from empty.
module pwb_fifo
  import img_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output logic [AW:0] count,
  input  wr_entry_t din,
  output wr_entry_t dout
);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  wr_entry_t     r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

endmodule

// File: rtl/pixel_write_buffer.sv
// Clip-checking pixel write buffer in front of a single RAM write port.
// PWB_OOR_LEGACY_ZERO_EN: zero out-of-range coordinates instead of dropping.
module pixel_write_buffer
  import img_pkg::*;
#(
  parameter int OFFSET       = 0,
  parameter int IMG_W        = img_pkg::IMG_W,
  parameter int IMG_H        = img_pkg::IMG_H,
  parameter int DEPTH        = 8,
  parameter int FRAME_PIXELS = img_pkg::FRAME_PIXELS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic [63:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        wr_ready,
  output logic        WRITE,
  output logic [31:0] addr,
  output logic [31:0] datain,
  output logic        frame_done,
  output logic [17:0] drop_count,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);

  logic          w_full;
  logic          w_empty;
  logic [AW:0]   w_count;
  wr_entry_t     w_din;
  wr_entry_t     w_dout;

  coord_t        w_x;
  coord_t        w_y;
  coord_t        w_xe;
  coord_t        w_ye;
  logic          w_x_ok;
  logic          w_y_ok;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_done;
  logic          w_unused;

  logic          r_write;
  logic [31:0]   r_addr;
  logic [31:0]   r_datain;
  logic          r_frame_done;
  logic [17:0]   r_drop;
  logic          r_ovf;
  logic [31:0]   r_pix_cnt;

  assign w_x      = pix_data[X_MSB:X_LSB];
  assign w_y      = pix_data[Y_MSB:Y_LSB];
  assign w_x_ok   = (32'(w_x) < 32'(IMG_W));
  assign w_y_ok   = (32'(w_y) < 32'(IMG_H));

  assign pix_ready = (w_count != (AW+1)'(DEPTH));
  assign w_accept  = pix_valid && pix_ready;
  assign w_pop     = !w_empty && wr_ready;

`ifdef PWB_OOR_LEGACY_ZERO_EN
  assign w_xe   = w_x_ok ? w_x : '0;
  assign w_ye   = w_y_ok ? w_y : '0;
  assign w_push = w_accept;
  assign w_drop = 1'b0;
`else
  assign w_xe   = w_x;
  assign w_ye   = w_y;
  assign w_push = w_accept && w_x_ok && w_y_ok;
  assign w_drop = w_accept && !(w_x_ok && w_y_ok);
`endif

  assign w_din.addr = pix_addr(w_xe, w_ye, IMG_W, OFFSET);
  assign w_din.rgb  = pix_data[23:0];

  assign w_done = (r_pix_cnt == 32'(FRAME_PIXELS))
               && w_empty && !r_write;

  assign w_unused = ^{pix_data[63:50], pix_data[31:24], w_full};

  pwb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count),
    .din   (w_din),
    .dout  (w_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_datain <= '0;
    end else begin
      r_write <= w_pop;
      if (w_pop) begin
        r_addr   <= w_dout.addr;
        r_datain <= {8'h00, w_dout.rgb};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (pix_valid && !pix_ready) begin
      r_ovf <= 1'b1;
    end
  end

  // A word accepted in the same cycle as a frame restart opens the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_done;
      if (frame_start || w_done) begin
        r_pix_cnt <= {31'd0, w_accept};
      end else if (w_accept) begin
        r_pix_cnt <= r_pix_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= '0;
    end else if (frame_start) begin
      r_drop <= {17'd0, w_drop};
    end else if (w_drop && (r_drop != '1)) begin
      r_drop <= r_drop + 18'd1;
    end
  end

  assign WRITE      = r_write;
  assign addr       = r_addr;
  assign datain     = r_datain;
  assign frame_done = r_frame_done;
  assign drop_count = r_drop;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Scoreboard bench for pixel_write_buffer: random and directed pixel
// streams against a queue-based model of the RAM write sequence.
module tb_pixel_write_buffer;
  import img_pkg::*;

  localparam int FP    = 1024;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        frame_start = 1'b0;
  logic [63:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        wr_ready;

  logic        pix_ready, WRITE, frame_done, overflow;
  logic [31:0] addr, datain;
  logic [17:0] drop_count;

  logic        t_ready, t_write, t_fd, t_ovf;
  logic [31:0] t_addr, t_datain;
  logic [17:0] t_drop;

  pixel_write_buffer #(
    .OFFSET(0), .IMG_W(320), .IMG_H(320),
    .DEPTH(DEPTH), .FRAME_PIXELS(FP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .wr_ready(wr_ready),
    .WRITE(WRITE), .addr(addr), .datain(datain),
    .frame_done(frame_done), .drop_count(drop_count),
    .overflow(overflow)
  );

  pixel_write_buffer #(
    .OFFSET(TMP_OFFSET), .IMG_W(320), .IMG_H(320),
    .DEPTH(DEPTH), .FRAME_PIXELS(FP)
  ) dut_tmp (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(t_ready), .wr_ready(wr_ready),
    .WRITE(t_write), .addr(t_addr), .datain(t_datain),
    .frame_done(t_fd), .drop_count(t_drop),
    .overflow(t_ovf)
  );

  always #5 clk = ~clk;

  int   wr_mode = 1;
  logic r_rand = 1'b1;
  always @(negedge clk) r_rand <= ($urandom_range(0, 3) != 0);
  assign wr_ready = (wr_mode == 2) ? r_rand : (wr_mode == 1);

  typedef struct {
    logic [31:0] a;
    logic [23:0] rgb;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   model_drop = 0;
  int   fd_cnt = 0;
  bit   fd_early = 1'b0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic pix_word_t mk(input int x, input int y,
                                   input logic [23:0] rgb);
    pix_word_t w;
    w = pix_word_t'({$urandom, $urandom});
    w[X_MSB:X_LSB] = coord_t'(x);
    w[Y_MSB:Y_LSB] = coord_t'(y);
    w[23:0] = rgb;
    return w;
  endfunction

  // Reference: what the RAM must see for one accepted word.
  function automatic void model_accept(input int x, input int y,
                                       input logic [23:0] rgb, input bit fs);
    exp_t e;
    bool_in: begin end
    if (fs) model_drop = 0;
    if (x < 320 && y < 320) begin
      e.a = 32'(x + y * 320);
      e.rgb = rgb;
      q.push_back(e);
    end else begin
`ifdef PWB_OOR_LEGACY_ZERO_EN
      e.a = 32'(((x < 320) ? x : 0) + ((y < 320) ? y : 0) * 320);
      e.rgb = rgb;
      q.push_back(e);
`else
      if (model_drop < 262143) model_drop++;
`endif
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (frame_done) begin
        fd_cnt++;
        if (q.size() != 0) fd_early = 1'b1;
      end
      if (WRITE) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr %0h expected none", addr);
        end else begin
          e = q.pop_front();
          check("wr_addr", 64'(addr), 64'(e.a));
          check("wr_data", 64'(datain), {40'd0, e.rgb});
          check("tmp_addr", 64'(t_addr), 64'(e.a + 32'(TMP_OFFSET)));
          check("tmp_same",
                64'({t_write, t_ready, t_fd, t_ovf, t_drop, t_datain}),
                64'({WRITE, pix_ready, frame_done, overflow,
                     drop_count, datain}));
        end
      end
    end
  end

  // Caller sits at a negedge; returns at the negedge after the accept edge.
  task automatic send(input int x, input int y, input logic [23:0] rgb,
                      input bit fs);
    int n = 0;
    pix_valid = 1'b0;
    frame_start = 1'b0;
    while (!pix_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      check("send_timeout", 64'(pix_ready), 64'd1);
    end else begin
      pix_data = mk(x, y, rgb);
      pix_valid = 1'b1;
      frame_start = fs;
      model_accept(x, y, rgb, fs);
      @(negedge clk);
      pix_valid = 1'b0;
      frame_start = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  int exp_drop;

  initial begin
    #3 rst_n = 1'b0;
    #2;
    check("rst_write", 64'(WRITE), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_datain", 64'(datain), 64'd0);
    check("rst_fd", 64'(frame_done), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(pix_ready), 64'd1);

    // Single pixel: latency and address
    send(5, 2, 24'hA1B2C3, 1'b0);
    check("lat_n", 64'(WRITE), 64'd0);
    @(negedge clk);
    check("lat_n1", 64'(WRITE), 64'd1);
    check("addr_645", 64'(addr), 64'd645);
    check("data_645", 64'(datain), 64'h00A1B2C3);
    wait_drain();

    send(319, 319, 24'h123456, 1'b0);
    @(negedge clk);
    check("addr_max", 64'(addr), 64'd102399);
    check("addr_tmp_max", 64'(t_addr), 64'd233471);
    wait_drain();

    // Out-of-range pair, then restart with a drop in the same cycle
    send(320, 0, 24'h111111, 1'b1);
    send(0, 400, 24'h222222, 1'b0);
    wait_drain();
`ifdef PWB_OOR_LEGACY_ZERO_EN
    exp_drop = 0;
`else
    exp_drop = 2;
`endif
    check("drop_two", 64'(drop_count), 64'(exp_drop));
    send(400, 3, 24'h333333, 1'b1);
    wait_drain();
    check("drop_fs_same", 64'(drop_count), 64'(exp_drop / 2));

    // Random mix with random back-pressure
    wr_mode = 2;
    for (int i = 0; i < 300; i++) begin
      send(int'($urandom_range(0, 420)), int'($urandom_range(0, 511)),
           24'($urandom), (i == 0));
    end
    wr_mode = 1;
    wait_drain();
    check("drop_rand", 64'(drop_count), 64'(model_drop));

    // Fill with RAM stalled, then overflow
    check("ovf_clear", 64'(overflow), 64'd0);
    wr_mode = 0;
    for (int i = 0; i < 9; i++) begin
      int x, y;
      logic [23:0] c;
      x = int'($urandom_range(0, 319));
      y = int'($urandom_range(0, 319));
      c = 24'($urandom);
      if (i == 8) check("ready_full", 64'(pix_ready), 64'd0);
      pix_data = mk(x, y, c);
      pix_valid = 1'b1;
      if (i < 8) model_accept(x, y, c, 1'b0);
      @(negedge clk);
    end
    pix_valid = 1'b0;
    check("ovf_set", 64'(overflow), 64'd1);
    check("ready_still0", 64'(pix_ready), 64'd0);
    check("q_eight", 64'(q.size()), 64'd8);
    wr_mode = 1;
    wait_drain();
    check("ready_back", 64'(pix_ready), 64'd1);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Reset with entries queued
    wr_mode = 0;
    for (int i = 0; i < 4; i++) send(i, 7, 24'(i + 16), 1'b0);
    wr_mode = 1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_write", 64'(WRITE), 64'd0);
    check("rst_mid_ovf", 64'(overflow), 64'd0);
    check("rst_mid_addr", 64'(addr), 64'd0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Full frame in raster order
    check("fd_none_yet", 64'(fd_cnt), 64'd0);
    wr_mode = 2;
    for (int i = 0; i < FP; i++) begin
      send(i % 320, i / 320, 24'($urandom), (i == 0));
    end
    for (int n = 0; n < 3000 && fd_cnt == 0; n++) @(negedge clk);
    check("fd_one", 64'(fd_cnt), 64'd1);
    check("fd_after_writes", 64'(fd_early), 64'd0);
    check("frame_q_empty", 64'(q.size()), 64'd0);
    check("frame_drop0", 64'(drop_count), 64'd0);
    repeat (20) @(negedge clk);
    check("fd_single", 64'(fd_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
